fir_fold_ctrl: RTL and testbench

//  Scheduler for a folded (time-multiplexed) FIR: one shared MAC serves all taps.

---
 rtl/fir_ctrl_pkg.sv | 16 +
 rtl/fir_tap_counter.sv | 28 ++
 rtl/fir_fold_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_fir_fold_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/fir_ctrl_pkg.sv
// fir_ctrl_pkg: shared state encoding and default sizing for the folded FIR controller.
package fir_ctrl_pkg;

  localparam int FIR_TAPS    = 8;
  localparam int FIR_ADDR_W  = 3;
  localparam int FIR_MAC_LAT = 1;

  typedef enum logic [2:0] {
    ST_CLR   = 3'd0,
    ST_IDLE  = 3'd1,
    ST_MAC   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_OUT   = 3'd4
  } state_t;

endpackage

// File: rtl/fir_tap_counter.sv
// fir_tap_counter: modulo-TAPS tap index with clear, enable and terminal flag.
// TAPS is a power of two, so the natural ADDR_W wrap is the modulo.
module fir_tap_counter #(
  parameter int TAPS   = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  output logic [ADDR_W-1:0] tap,
  output logic              term
);

  // Tap index register; clear wins over enable.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tap <= '0;
    end else if (clr) begin
      tap <= '0;
    end else if (en) begin
      tap <= tap + ADDR_W'(1);
    end
  end

  assign term = (tap == ADDR_W'(TAPS - 1));

endmodule

// File: rtl/fir_fold_ctrl.sv
// fir_fold_ctrl: scheduler for a folded FIR sharing one MAC across all taps.
// Build option: define FIR_COEF_WR_EN to let the host write coefficients while IDLE.
//
// state | meaning
// CLR   | zero-filling the delay line, one entry per cycle
// IDLE  | waiting for a sample (or a coefficient write)
// MAC   | stepping tap k through the shared MAC, one per cycle
// DRAIN | waiting out the MAC pipeline
// OUT   | result valid, waiting for out_ready
//
// Strobes are registered from the decode of the cycle they describe, so they
// show up one clock after the decision. The accepted sample is written in the
// same cycle as MAC k=0 reads that address; the delay RAM must be write-first.
module fir_fold_ctrl
  import fir_ctrl_pkg::*;
#(
  parameter int TAPS    = FIR_TAPS,
  parameter int ADDR_W  = FIR_ADDR_W,
  parameter int MAC_LAT = FIR_MAC_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              smp_we,
  output logic              smp_zero,
  output logic [ADDR_W-1:0] smp_waddr,
  output logic [ADDR_W-1:0] smp_raddr,
  output logic [ADDR_W-1:0] coef_addr,
  output logic              coef_we,
  output logic              mac_clr,
  output logic              mac_en,
  output logic              busy,
  input  logic              coef_wr_req,
  input  logic [ADDR_W-1:0] coef_wr_addr,
  output logic              coef_wr_ack
);

  localparam int DRN_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [DRN_W-1:0] DRN_LOAD = DRN_W'((MAC_LAT > 0) ? MAC_LAT - 1 : 0);

  state_t             state, state_d;
  logic [ADDR_W-1:0]  wr_ptr, wr_ptr_d;
  logic [DRN_W-1:0]   drn_cnt, drn_cnt_d;
  logic [ADDR_W-1:0]  tap, k_next;
  logic               tap_term, tap_clr, tap_en;
  logic               coef_grant;

  logic               smp_we_d, smp_zero_d, coef_we_d, coef_ack_d;
  logic               mac_clr_d, mac_en_d, out_valid_d;
  logic [ADDR_W-1:0]  smp_waddr_d, smp_raddr_d, coef_addr_d;

  fir_tap_counter #(
    .TAPS   (TAPS),
    .ADDR_W (ADDR_W)
  ) u_tap (
    .clk  (clk),
    .rst  (rst),
    .clr  (tap_clr),
    .en   (tap_en),
    .tap  (tap),
    .term (tap_term)
  );

`ifdef FIR_COEF_WR_EN
  // The ack cycle blocks a second grant so a host that drops req on ack writes once.
  assign coef_grant = (state == ST_IDLE) & coef_wr_req & ~coef_wr_ack;
`else
  logic unused_coef;
  assign unused_coef = ^{coef_wr_req, coef_wr_addr};
  assign coef_grant  = 1'b0;
`endif

  assign in_ready = (state == ST_IDLE) & ~coef_grant;
  assign k_next   = tap + ADDR_W'(1);

  // Next-state decode and the strobe values for the following cycle.
  always_comb begin
    state_d     = state;
    wr_ptr_d    = wr_ptr;
    drn_cnt_d   = drn_cnt;
    tap_clr     = 1'b0;
    tap_en      = 1'b0;
    smp_we_d    = 1'b0;
    smp_zero_d  = 1'b0;
    smp_waddr_d = '0;
    smp_raddr_d = '0;
    coef_addr_d = '0;
    coef_we_d   = 1'b0;
    coef_ack_d  = 1'b0;
    mac_clr_d   = 1'b0;
    mac_en_d    = 1'b0;
    out_valid_d = 1'b0;
    case (state)
      ST_CLR: begin
        smp_we_d    = 1'b1;
        smp_zero_d  = 1'b1;
        smp_waddr_d = tap;
        tap_en      = 1'b1;
        if (tap_term) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (coef_grant) begin
          coef_we_d   = 1'b1;
          coef_ack_d  = 1'b1;
          coef_addr_d = coef_wr_addr;
        end else if (in_valid) begin
          smp_we_d    = 1'b1;
          smp_waddr_d = wr_ptr;
          smp_raddr_d = wr_ptr;
          mac_en_d    = 1'b1;
          mac_clr_d   = 1'b1;
          tap_clr     = 1'b1;
          state_d     = ST_MAC;
        end
      end
      ST_MAC: begin
        tap_en = 1'b1;
        if (tap_term) begin
          if (MAC_LAT == 0) begin
            out_valid_d = 1'b1;
            state_d     = ST_OUT;
          end else begin
            drn_cnt_d = DRN_LOAD;
            state_d   = ST_DRAIN;
          end
        end else begin
          smp_raddr_d = wr_ptr - k_next;
          coef_addr_d = k_next;
          mac_en_d    = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drn_cnt == '0) begin
          out_valid_d = 1'b1;
          state_d     = ST_OUT;
        end else begin
          drn_cnt_d = drn_cnt - DRN_W'(1);
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          wr_ptr_d = wr_ptr + ADDR_W'(1);
          state_d  = ST_IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: state_d = ST_CLR;
    endcase
  end

  // State, pointer and registered strobes; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_CLR;
      wr_ptr      <= '0;
      drn_cnt     <= '0;
      smp_we      <= 1'b0;
      smp_zero    <= 1'b0;
      smp_waddr   <= '0;
      smp_raddr   <= '0;
      coef_addr   <= '0;
      coef_we     <= 1'b0;
      coef_wr_ack <= 1'b0;
      mac_clr     <= 1'b0;
      mac_en      <= 1'b0;
      out_valid   <= 1'b0;
      busy        <= 1'b1;
    end else begin
      state       <= state_d;
      wr_ptr      <= wr_ptr_d;
      drn_cnt     <= drn_cnt_d;
      smp_we      <= smp_we_d;
      smp_zero    <= smp_zero_d;
      smp_waddr   <= smp_waddr_d;
      smp_raddr   <= smp_raddr_d;
      coef_addr   <= coef_addr_d;
      coef_we     <= coef_we_d;
      coef_wr_ack <= coef_ack_d;
      mac_clr     <= mac_clr_d;
      mac_en      <= mac_en_d;
      out_valid   <= out_valid_d;
      busy        <= (state_d != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_fir_fold_ctrl.sv
// tb_fir_fold_ctrl: directed, table-driven bench for fir_fold_ctrl (TAPS=8, MAC_LAT=1).
module tb_fir_fold_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0, out_ready = 1'b0, coef_wr_req = 1'b0;
  logic [2:0] coef_wr_addr = 3'd0;
  logic       in_ready, out_valid, smp_we, smp_zero, coef_we, mac_clr, mac_en, busy, coef_wr_ack;
  logic [2:0] smp_waddr, smp_raddr, coef_addr;

  fir_fold_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .smp_we(smp_we), .smp_zero(smp_zero),
    .smp_waddr(smp_waddr), .smp_raddr(smp_raddr), .coef_addr(coef_addr), .coef_we(coef_we),
    .mac_clr(mac_clr), .mac_en(mac_en), .busy(busy), .coef_wr_req(coef_wr_req),
    .coef_wr_addr(coef_wr_addr), .coef_wr_ack(coef_wr_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       iv, ordy;
    logic       we, zero;
    logic [2:0] waddr, raddr, caddr;
    logic       clr, en, ov, bsy, ir;
  } vec_t;

  vec_t tbl[28];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   last, seen;
  logic [2:0] exp_w, gw, gr, gc;
  logic gz, found;

  function automatic vec_t mk(input int iv, ordy, we, zero, waddr, raddr, caddr,
                              input int clr, en, ov, bsy, ir);
    vec_t v;
    v.iv = iv[0]; v.ordy = ordy[0]; v.we = we[0]; v.zero = zero[0];
    v.waddr = waddr[2:0]; v.raddr = raddr[2:0]; v.caddr = caddr[2:0];
    v.clr = clr[0]; v.en = en[0]; v.ov = ov[0]; v.bsy = bsy[0]; v.ir = ir[0];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk(nm, {14'b0, smp_we, smp_zero, smp_waddr, smp_raddr, coef_addr, coef_we,
             coef_wr_ack, mac_clr, mac_en, out_valid, busy, in_ready},
        32'h0000_0002);
  endtask

  // Expects rst to have just been released: eight zero-fill writes, then IDLE.
  task automatic chk_clr_sequence(input string nm);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk(nm, {26'b0, smp_we, smp_zero, smp_waddr, in_ready},
          {26'b0, 1'b1, 1'b1, 3'(k), (k == 7)});
      chk({nm, "_busy"}, {31'b0, busy}, {31'b0, (k != 7)});
    end
  endtask

  initial begin
    // Transaction 1: wr_ptr=0, immediate out_ready.
    tbl[0]  = mk(1,0, 1,0,0, 0,0, 1,1, 0,1,0);
    tbl[1]  = mk(0,0, 0,0,0, 7,1, 0,1, 0,1,0);
    tbl[2]  = mk(0,0, 0,0,0, 6,2, 0,1, 0,1,0);
    tbl[3]  = mk(0,0, 0,0,0, 5,3, 0,1, 0,1,0);
    tbl[4]  = mk(0,0, 0,0,0, 4,4, 0,1, 0,1,0);
    tbl[5]  = mk(0,0, 0,0,0, 3,5, 0,1, 0,1,0);
    tbl[6]  = mk(0,0, 0,0,0, 2,6, 0,1, 0,1,0);
    tbl[7]  = mk(0,0, 0,0,0, 1,7, 0,1, 0,1,0);
    tbl[8]  = mk(0,0, 0,0,0, 0,0, 0,0, 0,1,0);
    tbl[9]  = mk(0,0, 0,0,0, 0,0, 0,0, 1,1,0);
    tbl[10] = mk(0,1, 0,0,0, 0,0, 0,0, 0,0,1);
    // Transaction 2: wr_ptr=1, out_ready low for 5 OUT cycles, in_valid held off.
    tbl[11] = mk(1,0, 1,0,1, 1,0, 1,1, 0,1,0);
    tbl[12] = mk(0,0, 0,0,0, 0,1, 0,1, 0,1,0);
    tbl[13] = mk(0,0, 0,0,0, 7,2, 0,1, 0,1,0);
    tbl[14] = mk(0,0, 0,0,0, 6,3, 0,1, 0,1,0);
    tbl[15] = mk(0,0, 0,0,0, 5,4, 0,1, 0,1,0);
    tbl[16] = mk(0,0, 0,0,0, 4,5, 0,1, 0,1,0);
    tbl[17] = mk(0,0, 0,0,0, 3,6, 0,1, 0,1,0);
    tbl[18] = mk(0,0, 0,0,0, 2,7, 0,1, 0,1,0);
    tbl[19] = mk(1,0, 0,0,0, 0,0, 0,0, 0,1,0);
    tbl[20] = mk(1,0, 0,0,0, 0,0, 0,0, 1,1,0);
    tbl[21] = mk(1,0, 0,0,0, 0,0, 0,0, 1,1,0);
    tbl[22] = mk(1,0, 0,0,0, 0,0, 0,0, 1,1,0);
    tbl[23] = mk(1,0, 0,0,0, 0,0, 0,0, 1,1,0);
    tbl[24] = mk(1,0, 0,0,0, 0,0, 0,0, 1,1,0);
    tbl[25] = mk(1,0, 0,0,0, 0,0, 0,0, 1,1,0);
    tbl[26] = mk(1,1, 0,0,0, 0,0, 0,0, 0,0,1);
    // Held sample is taken once IDLE is back; wr_ptr advanced exactly once.
    tbl[27] = mk(1,0, 1,0,2, 2,0, 1,1, 0,1,0);

    // Reset state, then zero-fill after release.
    tick();
    tick();
    chk_reset_outputs("reset_state");
    rst = 1'b1;
    chk_clr_sequence("clr_after_por");

    // Table-driven transactions.
    for (int i = 0; i < 28; i++) begin
      in_valid  = tbl[i].iv;
      out_ready = tbl[i].ordy;
      tick();
      gz = tbl[i].we ? smp_zero  : 1'b0;
      gw = tbl[i].we ? smp_waddr : 3'd0;
      gr = tbl[i].en ? smp_raddr : 3'd0;
      gc = tbl[i].en ? coef_addr : 3'd0;
      chk($sformatf("vec%0d", i),
          {16'b0, smp_we, gz, gw, gr, gc, mac_clr, mac_en, out_valid, busy, in_ready},
          {16'b0, tbl[i].we, tbl[i].zero, tbl[i].waddr, tbl[i].raddr, tbl[i].caddr,
           tbl[i].clr, tbl[i].en, tbl[i].ov, tbl[i].bsy, tbl[i].ir});
    end

    // Back-to-back: one accept every 11 cycles, write pointer wraps 7 -> 0.
    in_valid  = 1'b1;
    out_ready = 1'b1;
    last  = cyc;
    exp_w = 3'd3;
    seen  = 0;
    for (int i = 0; i < 150 && seen < 9; i++) begin
      tick();
      if (smp_we && !smp_zero) begin
        chk("b2b_period", 32'(cyc - last), 32'd11);
        chk("b2b_waddr", {29'b0, smp_waddr}, {29'b0, exp_w});
        last  = cyc;
        exp_w = exp_w + 3'd1;
        seen++;
      end
    end
    chk("b2b_count", 32'(seen), 32'd9);

    // Reset in the middle of MAC k=4 aborts and restarts the zero-fill.
    in_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (mac_en && coef_addr == 3'd4) found = 1'b1;
      else tick();
    end
    chk("mac_k4_reached", {31'b0, found}, 32'd1);
    rst = 1'b0;
    tick();
    chk_reset_outputs("reset_mid_mac");
    rst = 1'b1;
    chk_clr_sequence("clr_after_abort");

    // Coefficient write colliding with a sample in IDLE.
    in_valid     = 1'b1;
    coef_wr_req  = 1'b1;
    coef_wr_addr = 3'd3;
    out_ready    = 1'b0;
    #1;
`ifdef FIR_COEF_WR_EN
    chk("coef_blocks_ready", {31'b0, in_ready}, 32'd0);
    tick();
    chk("coef_grant", {26'b0, coef_we, coef_wr_ack, coef_addr, smp_we},
        {26'b0, 1'b1, 1'b1, 3'd3, 1'b0});
    coef_wr_req = 1'b0;
    #1;
    chk("ready_after_ack", {31'b0, in_ready}, 32'd1);
    tick();
    chk("sample_after_coef", {25'b0, coef_we, coef_wr_ack, smp_we, smp_zero, smp_waddr, mac_clr},
        {25'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1});
`else
    chk("coef_ignored_ready", {31'b0, in_ready}, 32'd1);
    tick();
    chk("coef_ignored", {26'b0, coef_we, coef_wr_ack, smp_we, smp_waddr, mac_clr},
        {26'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1});
    coef_wr_req = 1'b0;
`endif
    in_valid  = 1'b0;
    out_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (out_valid) found = 1'b1;
    end
    chk("final_out_valid", {31'b0, found}, 32'd1);
    tick();
    chk("final_idle", {29'b0, out_valid, busy, in_ready}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
